cg_reload_timer: RTL and testbench
==================================

# cg_reload_timer

Down-counting reload timer, the counterpart of the free-running up counter. It loads a programmable reload value and decrements to zero. At zero it emits a single-cycle expire pulse and sets a sticky interrupt flag. It then either stops (one-shot) or reloads (periodic). It sits beside the core as the tick/timeout source for watchdogs, pacing and periodic interrupts.

## Interface
- DATA_WIDTH, 32, width of the count and reload value
- PRESCALE_WIDTH, 8, width of i_prescale; exists only with CG_TIMER_PRESCALE_EN
- i_clk  in  1  clock; all logic on the rising edge
- i_rstn  in  1  synchronous, active-low reset, sampled on the i_clk rising edge
- i_start  in  1  load i_reload, latch i_periodic, enter RUN
- i_load  in  1  reload the count from i_reload without changing state
- i_cancel  in  1  return to IDLE; the count holds
- i_stop  in  1  freeze the count and prescaler while high
- i_periodic  in  1  mode, sampled only on i_start: 1 = periodic, 0 = one-shot
- i_reload  in  DATA_WIDTH  reload value R
- i_irq_clr  in  1  clear o_irq
- i_prescale  in  PRESCALE_WIDTH  divider P; exists only with CG_TIMER_PRESCALE_EN
- o_count  out  DATA_WIDTH  current count, registered
- o_expire  out  1  single-cycle expire pulse, registered
- o_irq  out  1  sticky expire flag
- o_running  out  1  high while the state is RUN

## Operation
- States:
  - IDLE: reset state.
  - RUN: counting.
  - EXPIRED: one-shot has finished.
- Reset (i_rstn=0 at an edge): state IDLE, o_count=0, o_expire=0, o_irq=0, o_running=0, prescaler=0, latched mode=0.
- Priority at each edge: reset > i_cancel > i_start > i_load > tick.
- i_start, from any state:
  - o_count<=R, prescaler<=0, mode<=i_periodic, state RUN.
  - A start during RUN restarts the timer.
- i_load: o_count<=R and prescaler<=0; state unchanged.
- i_cancel: state IDLE, o_count holds, o_expire=0 on that edge.
- Tick: in RUN with i_stop=0, one tick per enable (every cycle without the macro).
  - Tick with o_count≠0: o_count<=o_count-1.
  - Tick with o_count==0: o_expire<=1 for that one cycle.
    - Periodic: o_count<=R, sampling i_reload live at that edge; stay in RUN.
    - One-shot: state EXPIRED, o_count holds 0.
- Period is R+1 ticks. R=0 in periodic mode gives an expire on every tick.
- i_stop: no ticks; count and prescaler hold; o_running stays 1.
- o_expire is 0 on every edge that is not an expiring tick.
- o_irq:
  - Set on any edge where o_expire is set.
  - Cleared by i_irq_clr when no expire occurs.
  - Set wins over clear in the same cycle.
- Arithmetic is modulo 2^DATA_WIDTH. The count never underflows because 0 always reloads or stops.

## Timing
- All outputs are registered, with no combinational input-to-output paths.
- Start to first decrement: i_start at edge 0 gives o_count=R after edge 0 and R-1 after edge 1.
- One-shot: o_expire=1 after edge R+1. o_running falls on that same edge.
- Periodic: o_expire recurs every R+1 ticks. In the expire cycle o_count already shows R.
- i_stop high for N cycles delays the expire by exactly N cycles.
- Reset mid-RUN takes effect at the next edge, with all values as listed under Operation.

## Configuration
- CG_TIMER_PRESCALE_EN.
- Defined:
  - Adds PRESCALE_WIDTH and i_prescale, plus an internal prescaler.
  - In RUN with i_stop=0, the prescaler counts 0..P and issues one tick when it equals P, then returns to 0.
  - The count therefore moves once every P+1 cycles.
  - P is sampled live.
  - i_start and i_load clear the prescaler. i_stop freezes it.
- Undefined: no prescaler and no i_prescale port; one tick every cycle. Behaviour is identical to the defined build with P=0.

## Test plan
- Reset: drive i_rstn=0 for one edge during RUN with o_count=7 -> all outputs 0, state IDLE, no o_expire.
- One-shot: R=3, i_periodic=0, start at edge 0 -> o_count 3,2,1,0 after edges 0..3; o_expire=1 only after edge 4; o_running=0 from edge 4; o_count holds 0; o_irq=1.
- Periodic: R=2, i_periodic=1 -> o_count 2,1,0,2,1,0…; o_expire after edges 3, 6, 9; change i_reload to 4 before edge 6 -> o_count=4 after edge 6.
- Stop and cancel:
  - R=3, i_stop=1 during edges 1..2 -> o_count stays 3, o_expire after edge 6.
  - i_cancel asserted afterwards -> IDLE, count held, no further expires.
- IRQ collision:
  - i_irq_clr on the same edge as an expire -> o_irq stays 1.
  - i_irq_clr on the next edge -> o_irq=0.
- Prescale (macro on): P=1, R=1, start at edge 0 -> o_count=1 through edge 1, 0 after edge 2, o_expire after edge 4.

Source files
------------

// File: rtl/cg_reload_timer.sv
// Down-counting reload timer: loads R, counts to zero, pulses o_expire, then stops or reloads.
// Optional prescaler enabled by defining CG_TIMER_PRESCALE_EN.
module cg_reload_timer #(
    parameter int DATA_WIDTH = 32
`ifdef CG_TIMER_PRESCALE_EN
    , parameter int PRESCALE_WIDTH = 8
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
`ifdef CG_TIMER_PRESCALE_EN
    input  logic [PRESCALE_WIDTH-1:0] i_prescale,
`endif
    input  logic                  i_start,
    input  logic                  i_load,
    input  logic                  i_cancel,
    input  logic                  i_stop,
    input  logic                  i_periodic,
    input  logic [DATA_WIDTH-1:0] i_reload,
    input  logic                  i_irq_clr,
    output logic [DATA_WIDTH-1:0] o_count,
    output logic                  o_expire,
    output logic                  o_irq,
    output logic                  o_running
);

    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] count, count_n;
    logic                  expire, expire_n;
    logic                  irq, irq_n;
    logic                  mode, mode_n;
    logic                  at_div;

`ifdef CG_TIMER_PRESCALE_EN
    logic [PRESCALE_WIDTH-1:0] presc, presc_n;
    assign at_div = (presc == i_prescale);
`else
    assign at_div = 1'b1;
`endif

    always_comb begin
        state_n  = state;
        count_n  = count;
        expire_n = 1'b0;
        mode_n   = mode;
`ifdef CG_TIMER_PRESCALE_EN
        presc_n  = presc;
`endif
        if (i_cancel) begin
            state_n = IDLE;
        end else if (i_start) begin
            count_n = i_reload;
            mode_n  = i_periodic;
            state_n = RUN;
`ifdef CG_TIMER_PRESCALE_EN
            presc_n = '0;
`endif
        end else if (i_load) begin
            count_n = i_reload;
`ifdef CG_TIMER_PRESCALE_EN
            presc_n = '0;
`endif
        end else if (state == RUN && !i_stop) begin
`ifdef CG_TIMER_PRESCALE_EN
            presc_n = at_div ? '0 : presc + PRESCALE_WIDTH'(1);
`endif
            if (at_div) begin
                if (count != '0) begin
                    count_n = count - DATA_WIDTH'(1);
                end else begin
                    // Zero never decrements: it either reloads live or parks in EXPIRED.
                    expire_n = 1'b1;
                    if (mode) count_n = i_reload;
                    else      state_n = EXPIRED;
                end
            end
        end
        // Set beats clear when both land on the same edge.
        irq_n = expire_n | (irq & ~i_irq_clr);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state  <= IDLE;
            count  <= '0;
            expire <= 1'b0;
            irq    <= 1'b0;
            mode   <= 1'b0;
`ifdef CG_TIMER_PRESCALE_EN
            presc  <= '0;
`endif
        end else begin
            state  <= state_n;
            count  <= count_n;
            expire <= expire_n;
            irq    <= irq_n;
            mode   <= mode_n;
`ifdef CG_TIMER_PRESCALE_EN
            presc  <= presc_n;
`endif
        end
    end

    assign o_count   = count;
    assign o_expire  = expire;
    assign o_irq     = irq;
    assign o_running = (state == RUN);

endmodule

// File: tb/tb_cg_reload_timer.sv
// Self-checking bench for cg_reload_timer: directed scenarios plus random traffic vs a reference model.
module tb_cg_reload_timer;

    logic        clk = 1'b0;
    logic        rstn, start, load, cancel, stop, periodic, irq_clr;
    logic [31:0] reload;
    logic [31:0] count;
    logic        expire, irq, running;
`ifdef CG_TIMER_PRESCALE_EN
    logic [7:0]  prescale;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    cg_reload_timer dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
`ifdef CG_TIMER_PRESCALE_EN
        .i_prescale (prescale),
`endif
        .i_start    (start),
        .i_load     (load),
        .i_cancel   (cancel),
        .i_stop     (stop),
        .i_periodic (periodic),
        .i_reload   (reload),
        .i_irq_clr  (irq_clr),
        .o_count    (count),
        .o_expire   (expire),
        .o_irq      (irq),
        .o_running  (running)
    );

    always #5 clk = ~clk;

    // Reference model: timer phase as plain integers.
    bit          m_run, m_done, m_mode, m_exp, m_irq;
    longint      m_cnt;
    int          m_pre;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        int p;
        bit tick;
`ifdef CG_TIMER_PRESCALE_EN
        p = int'(prescale);
`else
        p = 0;
`endif
        m_exp = 0;
        if (!rstn) begin
            m_run = 0; m_done = 0; m_mode = 0; m_cnt = 0; m_pre = 0; m_irq = 0;
            return;
        end
        if (cancel) begin
            m_run = 0; m_done = 0;
        end else if (start) begin
            m_cnt = reload; m_pre = 0; m_mode = periodic; m_run = 1; m_done = 0;
        end else if (load) begin
            m_cnt = reload; m_pre = 0;
        end else if (m_run && !stop) begin
            tick  = (m_pre == p);
            m_pre = tick ? 0 : m_pre + 1;
            if (tick) begin
                if (m_cnt > 0) m_cnt = m_cnt - 1;
                else begin
                    m_exp = 1;
                    if (m_mode) m_cnt = reload;
                    else begin m_run = 0; m_done = 1; end
                end
            end
        end
        if (m_exp) m_irq = 1;
        else if (irq_clr) m_irq = 0;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("count",   count,          32'(m_cnt));
        chk("expire",  32'(expire),    32'(m_exp));
        chk("irq",     32'(irq),       32'(m_irq));
        chk("running", 32'(running),   32'(m_run));
    endtask

    task automatic idle_inputs();
        start = 0; load = 0; cancel = 0; stop = 0; irq_clr = 0;
    endtask

    initial begin
        rstn = 0; periodic = 0; reload = 0;
        idle_inputs();
`ifdef CG_TIMER_PRESCALE_EN
        prescale = 0;
`endif
        cyc(); cyc();
        chk("rst_count", count, 0);
        chk("rst_run", 32'(running), 0);
        rstn = 1;

        // Reset while running with count 7
        reload = 7; start = 1; cyc(); start = 0;
        stop = 1; cyc(); cyc();
        chk("pre_rst_count", count, 7);
        rstn = 0; cyc(); rstn = 1; stop = 0;
        chk("rst7_count", count, 0);
        chk("rst7_run", 32'(running), 0);
        chk("rst7_exp", 32'(expire), 0);
        chk("rst7_irq", 32'(irq), 0);

        // One-shot R=3
        reload = 3; periodic = 0; start = 1; cyc(); start = 0;
        chk("os_e0", count, 3);
        cyc(); chk("os_e1", count, 2);
        cyc(); chk("os_e2", count, 1);
        cyc(); chk("os_e3", count, 0); chk("os_e3_exp", 32'(expire), 0);
        cyc(); chk("os_e4_exp", 32'(expire), 1); chk("os_e4_run", 32'(running), 0);
        chk("os_e4_irq", 32'(irq), 1);
        cyc(); chk("os_hold", count, 0); chk("os_e5_exp", 32'(expire), 0);
        irq_clr = 1; cyc(); irq_clr = 0;
        chk("os_irq_clr", 32'(irq), 0);

        // Periodic R=2, reload changed to 4 before edge 6
        reload = 2; periodic = 1; start = 1; cyc(); start = 0;
        chk("per_e0", count, 2);
        cyc(); cyc(); chk("per_e2", count, 0);
        cyc(); chk("per_e3_exp", 32'(expire), 1); chk("per_e3_cnt", count, 2);
        cyc(); cyc();
        reload = 4; cyc();
        chk("per_e6_exp", 32'(expire), 1); chk("per_e6_cnt", count, 4);

        // IRQ clear colliding with expire
        irq_clr = 1;
        repeat (4) cyc();
        chk("col_pre_irq", 32'(irq), 0);
        cyc(); chk("col_exp", 32'(expire), 1); chk("col_irq", 32'(irq), 1);
        cyc(); chk("col_clr", 32'(irq), 0);
        irq_clr = 0;

        // Stop during edges 1..2 delays one-shot expire to edge 6
        reload = 3; periodic = 0; start = 1; cyc(); start = 0;
        stop = 1; cyc(); cyc(); stop = 0;
        chk("stop_hold", count, 3); chk("stop_run", 32'(running), 1);
        cyc(); cyc(); cyc();
        chk("stop_e5_exp", 32'(expire), 0);
        cyc(); chk("stop_e6_exp", 32'(expire), 1);

        // Cancel mid-run holds the count and silences expires
        reload = 3; periodic = 1; start = 1; cyc(); start = 0;
        cyc(); cyc();
        cancel = 1; cyc(); cancel = 0;
        chk("cancel_run", 32'(running), 0); chk("cancel_cnt", count, 1);
        repeat (8) begin
            cyc(); chk("cancel_quiet", 32'(expire), 0);
        end

`ifdef CG_TIMER_PRESCALE_EN
        // Prescale P=1, R=1
        prescale = 1; reload = 1; periodic = 0; start = 1; cyc(); start = 0;
        cyc(); chk("ps_e1", count, 1);
        cyc(); chk("ps_e2", count, 0);
        cyc(); chk("ps_e3_exp", 32'(expire), 0);
        cyc(); chk("ps_e4_exp", 32'(expire), 1);
`endif

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            rstn     = ($urandom_range(0, 199) != 0);
            cancel   = ($urandom_range(0, 49) == 0);
            start    = ($urandom_range(0, 29) == 0);
            load     = ($urandom_range(0, 39) == 0);
            stop     = ($urandom_range(0, 6) == 0);
            irq_clr  = ($urandom_range(0, 9) == 0);
            periodic = $urandom_range(0, 1) == 1;
            reload   = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 6));
`ifdef CG_TIMER_PRESCALE_EN
            prescale = 8'($urandom_range(0, 3));
`endif
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
